chunked_adder: RTL and testbench



---
 rtl/chunked_adder.sv | 165 ++++++++++++++++
 tb/tb_chunked_adder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder
// Description : Multi-cycle adder/subtractor, CHUNK bits per clock, LSB first,
//               with valid/ready handshake, carry-out and signed overflow.
//               Optional zero flag: define CHUNKED_ADDER_ZERO_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             overflow
);

    localparam int c_NUM_CHUNKS = WIDTH / CHUNK;
    localparam int c_CNT_W      = (c_NUM_CHUNKS > 1) ? $clog2(c_NUM_CHUNKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_cout;
    logic               r_ovf;

    logic [CHUNK:0]     w_sum;
    logic [WIDTH-1:0]   w_a_shift;
    logic [WIDTH-1:0]   w_b_shift;
    logic [WIDTH-1:0]   w_s_shift;
    logic               w_last;
    logic               w_accept;
    logic               w_msb_cin;
    logic               w_ovf;

    // Operands are consumed from the bottom of r_a/r_b; results enter r_s at the top.
    assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};

    generate
        if (c_NUM_CHUNKS > 1) begin : g_multi
            assign w_a_shift = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
            assign w_b_shift = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
            assign w_s_shift = {w_sum[CHUNK-1:0], r_s[WIDTH-1:CHUNK]};
        end else begin : g_single
            assign w_a_shift = r_a;
            assign w_b_shift = r_b;
            assign w_s_shift = w_sum[CHUNK-1:0];
        end
    endgenerate

    assign w_last    = (r_cnt == c_LAST);
    assign w_accept  = in_valid && (r_state == ST_IDLE);
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign w_msb_cin = w_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
    assign w_ovf     = w_msb_cin ^ w_sum[CHUNK];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + ~borrow.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ^ c_in;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= w_a_shift;
            r_b     <= w_b_shift;
            r_s     <= w_s_shift;
            r_carry <= w_sum[CHUNK];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_sum[CHUNK];
                r_ovf  <= w_ovf;
            end
        end
    end

`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last) begin
            r_zero <= (w_s_shift == '0);
        end
    end

    assign zero = r_zero;
`endif

    assign s        = r_s;
    assign c_out    = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_adder
// Description : Self-checking bench for chunked_adder: directed cases plus a
//               random sweep over four WIDTH/CHUNK configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv_m, iv_s, ordy_m, ordy_s;
    logic [15:0] a, b;
    logic        cin, sub;

    logic        ir [4];
    logic        ov [4];
    logic        co [4];
    logic        of [4];
    logic [15:0] so [4];
    logic [7:0]  s8;
`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
    logic        zf [4];
`endif

    int checks   = 0;
    int failures = 0;

    int width_v [4] = '{16, 16, 16, 8};
    int nch_v   [4] = '{4, 16, 1, 2};

    assign so[3] = {8'h00, s8};

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_main (
        .clk(clk), .reset(reset), .in_valid(iv_m), .in_ready(ir[0]),
        .a(a), .b(b), .c_in(cin), .sub(sub),
        .out_valid(ov[0]), .out_ready(ordy_m), .s(so[0]), .c_out(co[0]),
`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
        .zero(zf[0]),
`endif
        .overflow(of[0])
    );

    chunked_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .reset(reset), .in_valid(iv_s), .in_ready(ir[1]),
        .a(a), .b(b), .c_in(cin), .sub(sub),
        .out_valid(ov[1]), .out_ready(ordy_s), .s(so[1]), .c_out(co[1]),
`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
        .zero(zf[1]),
`endif
        .overflow(of[1])
    );

    chunked_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .reset(reset), .in_valid(iv_s), .in_ready(ir[2]),
        .a(a), .b(b), .c_in(cin), .sub(sub),
        .out_valid(ov[2]), .out_ready(ordy_s), .s(so[2]), .c_out(co[2]),
`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
        .zero(zf[2]),
`endif
        .overflow(of[2])
    );

    chunked_adder #(.WIDTH(8), .CHUNK(4)) u_w8 (
        .clk(clk), .reset(reset), .in_valid(iv_s), .in_ready(ir[3]),
        .a(a[7:0]), .b(b[7:0]), .c_in(cin), .sub(sub),
        .out_valid(ov[3]), .out_ready(ordy_s), .s(s8), .c_out(co[3]),
`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
        .zero(zf[3]),
`endif
        .overflow(of[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Golden model from integer arithmetic: {zero, overflow, c_out, s[15:0]}.
    function automatic logic [18:0] model(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic ci,
                                          input logic is_sub);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(av) & m;
        longint ub   = longint'(bv) & m;
        longint sa   = (ua >= half) ? ua - (m + 1) : ua;
        longint sb   = (ub >= half) ? ub - (m + 1) : ub;
        longint c    = longint'(ci);
        longint r, sr;
        logic   cy, vf;
        if (!is_sub) begin
            r  = ua + ub + c;
            cy = (r > m);
            sr = sa + sb + c;
        end else begin
            r  = ua - ub - c;
            cy = (ua >= ub + c);
            sr = sa - sb - c;
        end
        vf = (sr >= half) || (sr < -half);
        r  = r & m;
        return {(r == 0), vf, cy, r[15:0]};
    endfunction

    task automatic accept_main(input logic [15:0] av, input logic [15:0] bv,
                               input logic ci, input logic is_sub);
        int t = 0;
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = is_sub; iv_m = 1'b1;
        while (!ir[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 iv_m = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] av, input logic [15:0] bv,
                               input logic ci, input logic is_sub);
        int lat = 0;
        logic [18:0] e;
        e = model(16, av, bv, ci, is_sub);
        while (!ov[0] && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_s"}, {16'h0, so[0]}, {16'h0, e[15:0]});
        chk({tag, "_cout"}, {31'h0, co[0]}, {31'h0, e[16]});
        chk({tag, "_ovf"}, {31'h0, of[0]}, {31'h0, e[17]});
`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
        chk({tag, "_zero"}, {31'h0, zf[0]}, {31'h0, e[18]});
`endif
    endtask

    task automatic consume_main();
        ordy_m = 1'b1;
        @(posedge clk);
        #1 ordy_m = 1'b0;
        chk("consume_ovalid", {31'h0, ov[0]}, 32'd0);
    endtask

    task automatic run_main(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic ci, input logic is_sub);
        accept_main(av, bv, ci, is_sub);
        wait_result(tag, av, bv, ci, is_sub);
        consume_main();
    endtask

    initial begin
        reset = 1'b1;
        iv_m = 1'b0; iv_s = 1'b0; ordy_m = 1'b0; ordy_s = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, ir[0]}, 32'd1);
        chk("rst_out_valid", {31'h0, ov[0]}, 32'd0);
        chk("rst_s", {16'h0, so[0]}, 32'd0);
        chk("rst_cout", {31'h0, co[0]}, 32'd0);
        chk("rst_ovf", {31'h0, of[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed arithmetic cases.
        run_main("add_1_3", 16'h0001, 16'h0003, 1'b0, 1'b0);
        run_main("add_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        run_main("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_main("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1);
        run_main("sub_7_5b", 16'h0007, 16'h0005, 1'b1, 1'b1);
        run_main("sub_eq", 16'h1234, 16'h1234, 1'b0, 1'b1);
        run_main("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);

        // Backpressure: result held, no second accept while DONE.
        accept_main(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_result("bp", 16'h1111, 16'h2222, 1'b0, 1'b0);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; iv_m = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_ovalid", i), {31'h0, ov[0]}, 32'd1);
            chk($sformatf("bp_hold%0d_s", i), {16'h0, so[0]}, 32'h3333);
            chk($sformatf("bp_hold%0d_inrdy", i), {31'h0, ir[0]}, 32'd0);
        end
        ordy_m = 1'b1;
        @(posedge clk);
        #1 ordy_m = 1'b0;
        chk("bp_release_ovalid", {31'h0, ov[0]}, 32'd0);
        chk("bp_release_inrdy", {31'h0, ir[0]}, 32'd1);
        @(posedge clk);
        #1 iv_m = 1'b0;
        wait_result("bp_next", 16'hAAAA, 16'h5555, 1'b0, 1'b0);
        consume_main();

        // Asynchronous reset two cycles into RUN.
        accept_main(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_ovalid", {31'h0, ov[0]}, 32'd0);
        chk("arst_s", {16'h0, so[0]}, 32'd0);
        chk("arst_inrdy", {31'h0, ir[0]}, 32'd1);
        chk("arst_cout", {31'h0, co[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_main("post_rst", 16'h0010, 16'h0020, 1'b0, 1'b0);

        // Random sweep across all four configurations in lockstep.
        ordy_m = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            int   lat [4];
            logic seen [4];
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            iv_m = 1'b1; iv_s = 1'b1;
            @(posedge clk);
            #1 iv_m = 1'b0; iv_s = 1'b0;
            for (int i = 0; i < 4; i++) begin
                seen[i] = 1'b0;
                lat[i]  = 0;
            end
            for (int cyc = 1; cyc <= 20; cyc++) begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    if (ov[i] && !seen[i]) begin
                        logic [18:0] e;
                        e       = model(width_v[i], a, b, cin, sub);
                        seen[i] = 1'b1;
                        lat[i]  = cyc;
                        chk($sformatf("sw%0d_lat", i), cyc, nch_v[i]);
                        chk($sformatf("sw%0d_s", i), {16'h0, so[i]}, {16'h0, e[15:0]});
                        chk($sformatf("sw%0d_cout", i), {31'h0, co[i]}, {31'h0, e[16]});
                        chk($sformatf("sw%0d_ovf", i), {31'h0, of[i]}, {31'h0, e[17]});
`ifdef CHUNKED_ADDER_ZERO_FLAG_EN
                        chk($sformatf("sw%0d_zero", i), {31'h0, zf[i]}, {31'h0, e[18]});
`endif
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!seen[i]) chk($sformatf("sw%0d_timeout", i), 32'd0, 32'd1);
            end
        end
        ordy_m = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
